flush_redirect_ctrl: RTL and testbench

Sequences pipeline recovery after a branch mispredict or a committed trap. It selects the oldest pending recovery event relative to the ROB head and drives flush pulses to the frontend and backend. It waits for the backend to quiesce, then issues a single-cycle PC redirect. It sits beside the hazard/stall logic and merges that logic's dispatch stall with its own recovery stalls, giving one set of stall outputs for fetch, decode and dispatch.

---
 rtl/flush_pkg.sv | 23 ++
 rtl/flush_redirect_ctrl_if.sv | 44 ++++
 rtl/flush_redirect_ctrl_rob_age_cmp.sv | 24 ++
 rtl/flush_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_flush_redirect_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flush_pkg.sv
// Shared types and helpers for the flush/redirect recovery controller.
package flush_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Ages are computed in a fixed-width container; ROB_SIZE must not exceed 2**AGE_W.
  localparam int AGE_W = 16;

  // Distance of a ROB index from the head, modulo the ROB size (0 = oldest).
  function automatic logic [AGE_W-1:0] rob_age(input logic [AGE_W-1:0] idx,
                                               input logic [AGE_W-1:0] head,
                                               input int               idx_w);
    logic [AGE_W-1:0] mask;
    mask = (AGE_W'(1) << idx_w) - AGE_W'(1);
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/flush_redirect_ctrl_if.sv
// Recovery-event inputs, flush/redirect outputs and merged stalls of the controller.
interface flush_redirect_ctrl_if #(
  parameter int XLEN     = 32,
  parameter int ROB_SIZE = 16
);
  localparam int IDX_W = $clog2(ROB_SIZE);

  logic             hazard_stall;
  logic [IDX_W-1:0] rob_head_idx;
  logic             mispredict_valid;
  logic [IDX_W-1:0] mispredict_rob_idx;
  logic [XLEN-1:0]  mispredict_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             backend_quiesced;

  logic             flush_frontend;
  logic             flush_backend;
  logic             flush_all;
  logic [IDX_W-1:0] flush_rob_idx;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             stall_fetch;
  logic             stall_decode;
  logic             stall_dispatch;
  logic             busy;
  logic [15:0]      flush_count;

  modport master (
    output hazard_stall, rob_head_idx, mispredict_valid, mispredict_rob_idx,
           mispredict_target, trap_valid, trap_vector, backend_quiesced,
    input  flush_frontend, flush_backend, flush_all, flush_rob_idx,
           redirect_valid, redirect_pc, stall_fetch, stall_decode,
           stall_dispatch, busy, flush_count
  );

  modport slave (
    input  hazard_stall, rob_head_idx, mispredict_valid, mispredict_rob_idx,
           mispredict_target, trap_valid, trap_vector, backend_quiesced,
    output flush_frontend, flush_backend, flush_all, flush_rob_idx,
           redirect_valid, redirect_pc, stall_fetch, stall_decode,
           stall_dispatch, busy, flush_count
  );
endinterface

// File: rtl/flush_redirect_ctrl_rob_age_cmp.sv
// Decides whether ROB entry a is strictly older than entry b relative to the head.
module rob_age_cmp
  import flush_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] i_head,
  input  logic [IDX_W-1:0] i_a,
  input  logic [IDX_W-1:0] i_b,
  output logic             o_a_older
);

  logic [AGE_W-1:0] w_age_a;
  logic [AGE_W-1:0] w_age_b;

  // Wrap-aware ages; handles indices that sit numerically below the head.
  always_comb begin
    w_age_a = rob_age(AGE_W'(i_a), AGE_W'(i_head), IDX_W);
    w_age_b = rob_age(AGE_W'(i_b), AGE_W'(i_head), IDX_W);
  end

  assign o_a_older = (w_age_a < w_age_b);

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Pipeline recovery sequencer: flush, wait for backend quiesce, redirect fetch.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | no recovery in progress, accepts trap or mispredict
//   ST_FLUSH    | flush pulses held for FLUSH_CYCLES cycles
//   ST_DRAIN    | flushes done, waiting for backend_quiesced
//   ST_REDIRECT | one-cycle redirect strobe to fetch, new events ignored
module flush_redirect_ctrl
  import flush_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ROB_SIZE     = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  flush_redirect_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [XLEN-1:0]  r_pend_pc;
  logic [IDX_W-1:0] r_pend_idx;
  logic             r_pend_trap;
  logic [15:0]      r_count;
  logic             w_accept;
  logic             w_mp_older;

  rob_age_cmp #(.IDX_W(IDX_W)) u_age_cmp (
    .i_head    (bus.rob_head_idx),
    .i_a       (bus.mispredict_rob_idx),
    .i_b       (r_pend_idx),
    .o_a_older (w_mp_older)
  );

  // Next-state, flush timer and event acceptance (trap beats mispredict).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = bus.trap_valid | bus.mispredict_valid;
      end
      ST_FLUSH, ST_DRAIN: begin
        if (bus.trap_valid) begin
          w_accept = 1'b1;
        end else if (bus.mispredict_valid && !r_pend_trap && w_mp_older) begin
          w_accept = 1'b1;
        end else if (r_state == ST_FLUSH) begin
          if (r_cnt == '0) w_state_nxt = ST_DRAIN;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end else if (bus.backend_quiesced) begin
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = ST_FLUSH;
      w_cnt_nxt   = CNT_LOAD;
    end
  end

  // State, timer, pending event and saturating event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend_pc   <= '0;
      r_pend_idx  <= '0;
      r_pend_trap <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        // A trap flushes everything, so its boundary is just the current head.
        r_pend_trap <= bus.trap_valid;
        r_pend_pc   <= bus.trap_valid ? bus.trap_vector  : bus.mispredict_target;
        r_pend_idx  <= bus.trap_valid ? bus.rob_head_idx : bus.mispredict_rob_idx;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign bus.flush_frontend = (r_state == ST_FLUSH);
  assign bus.flush_backend  = (r_state == ST_FLUSH);
  assign bus.flush_all      = (r_state == ST_FLUSH) & r_pend_trap;
  assign bus.flush_rob_idx  = r_pend_idx;
  assign bus.redirect_valid = (r_state == ST_REDIRECT);
  assign bus.redirect_pc    = r_pend_pc;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.flush_count    = r_count;

  // Fetch is released in REDIRECT so the new path can start immediately.
  assign bus.stall_fetch    = rst | bus.hazard_stall |
                              (r_state == ST_FLUSH) | (r_state == ST_DRAIN);
  assign bus.stall_decode   = rst | bus.hazard_stall | (r_state != ST_IDLE);
  assign bus.stall_dispatch = rst | bus.hazard_stall | (r_state != ST_IDLE);

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Self-checking bench for flush_redirect_ctrl: scripted scenarios plus random traffic.
module tb_flush_redirect_ctrl;
  localparam int XLEN = 32;
  localparam int ROB  = 16;
  localparam int FC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  flush_redirect_ctrl_if #(.XLEN(XLEN), .ROB_SIZE(ROB)) bus ();

  flush_redirect_ctrl #(.XLEN(XLEN), .ROB_SIZE(ROB), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 flushing, 2 draining, 3 redirecting.
  int m_phase, m_left, m_idx, m_count;
  logic [31:0] m_pc;
  bit m_trap;

  function automatic int age(int i, int h);
    return (i - h + ROB) % ROB;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_idx = 0; m_count = 0; m_pc = '0; m_trap = 0;
  endtask

  task automatic model_update();
    bit acc;
    acc = 0;
    if (m_phase == 0) acc = bus.trap_valid || bus.mispredict_valid;
    else if (m_phase == 1 || m_phase == 2) begin
      if (bus.trap_valid) acc = 1;
      else if (bus.mispredict_valid && !m_trap &&
               age(int'(bus.mispredict_rob_idx), int'(bus.rob_head_idx)) <
               age(m_idx, int'(bus.rob_head_idx))) acc = 1;
    end
    if (acc) begin
      if (m_count < 65535) m_count++;
      if (bus.trap_valid) begin
        m_trap = 1; m_pc = bus.trap_vector; m_idx = int'(bus.rob_head_idx);
      end else begin
        m_trap = 0; m_pc = bus.mispredict_target; m_idx = int'(bus.mispredict_rob_idx);
      end
      m_phase = 1; m_left = FC;
    end else begin
      case (m_phase)
        1: begin m_left--; if (m_left == 0) m_phase = 2; end
        2: if (bus.backend_quiesced) m_phase = 3;
        3: m_phase = 0;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hazard_stall = 0; bus.rob_head_idx = '0; bus.mispredict_valid = 0;
    bus.mispredict_rob_idx = '0; bus.mispredict_target = '0; bus.trap_valid = 0;
    bus.trap_vector = '0; bus.backend_quiesced = 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic mispredict(input int idx, input logic [31:0] tgt);
    bus.mispredict_valid = 1; bus.mispredict_rob_idx = 4'(idx); bus.mispredict_target = tgt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    #2;
    n_checks++;
    if (bus.busy !== 0 || bus.flush_backend !== 0 || bus.redirect_valid !== 0 ||
        bus.flush_count !== 16'd0 || bus.flush_all !== 0) begin
      n_err++; $display("FAIL reset_outputs: busy=%b fb=%b rv=%b cnt=%0d fa=%b, required all 0",
                        bus.busy, bus.flush_backend, bus.redirect_valid, bus.flush_count, bus.flush_all);
    end
    n_checks++;
    if ({bus.stall_fetch, bus.stall_decode, bus.stall_dispatch} !== 3'b111) begin
      n_err++; $display("FAIL reset_stalls: got %b%b%b required 111",
                        bus.stall_fetch, bus.stall_decode, bus.stall_dispatch);
    end
    do_reset();
  endtask

  task automatic test_basic_mispredict();
    do_reset();
    bus.rob_head_idx = 4'd3;
    mispredict(5, 32'h100);
    tick();
    bus.mispredict_valid = 0;
    n_checks++;
    if (bus.flush_backend !== 1 || bus.flush_frontend !== 1 || bus.flush_rob_idx !== 4'd5 ||
        bus.flush_all !== 0) begin
      n_err++; $display("FAIL basic_flush1: fb=%b ff=%b idx=%0d fa=%b required 1 1 5 0",
                        bus.flush_backend, bus.flush_frontend, bus.flush_rob_idx, bus.flush_all);
    end
    tick();
    n_checks++;
    if (bus.flush_backend !== 1) begin
      n_err++; $display("FAIL basic_flush2: fb=%b required 1", bus.flush_backend);
    end
    tick();
    n_checks++;
    if (bus.flush_backend !== 0 || bus.redirect_valid !== 0 || bus.busy !== 1) begin
      n_err++; $display("FAIL basic_drain: fb=%b rv=%b busy=%b required 0 0 1",
                        bus.flush_backend, bus.redirect_valid, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== 32'h100 || bus.flush_count !== 16'd1) begin
      n_err++; $display("FAIL basic_redirect: rv=%b pc=%h cnt=%0d required 1 100 1",
                        bus.redirect_valid, bus.redirect_pc, bus.flush_count);
    end
    tick();
    n_checks++;
    if (bus.redirect_valid !== 0 || bus.busy !== 0) begin
      n_err++; $display("FAIL basic_idle: rv=%b busy=%b required 0 0", bus.redirect_valid, bus.busy);
    end
  endtask

  task automatic test_override();
    do_reset();
    bus.rob_head_idx = 4'd14;
    mispredict(1, 32'h200);
    tick();
    mispredict(15, 32'h300);
    tick();
    n_checks++;
    if (bus.flush_rob_idx !== 4'd15 || bus.flush_backend !== 1 || bus.flush_count !== 16'd2) begin
      n_err++; $display("FAIL override_take: idx=%0d fb=%b cnt=%0d required 15 1 2",
                        bus.flush_rob_idx, bus.flush_backend, bus.flush_count);
    end
    mispredict(2, 32'h400);
    tick();
    bus.mispredict_valid = 0;
    n_checks++;
    if (bus.flush_rob_idx !== 4'd15 || bus.flush_backend !== 1 || bus.flush_count !== 16'd2) begin
      n_err++; $display("FAIL override_ignore_younger: idx=%0d fb=%b cnt=%0d required 15 1 2",
                        bus.flush_rob_idx, bus.flush_backend, bus.flush_count);
    end
    tick();
    n_checks++;
    if (bus.flush_backend !== 0) begin
      n_err++; $display("FAIL override_drain: fb=%b required 0", bus.flush_backend);
    end
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== 32'h300) begin
      n_err++; $display("FAIL override_redirect: rv=%b pc=%h required 1 300",
                        bus.redirect_valid, bus.redirect_pc);
    end
  endtask

  task automatic test_trap_priority();
    do_reset();
    bus.rob_head_idx = 4'd0;
    bus.backend_quiesced = 0;
    mispredict(4, 32'h500);
    bus.trap_valid = 1; bus.trap_vector = 32'h80;
    tick();
    bus.mispredict_valid = 0; bus.trap_valid = 0;
    n_checks++;
    if (bus.flush_all !== 1 || bus.flush_backend !== 1) begin
      n_err++; $display("FAIL trap_flush_all: fa=%b fb=%b required 1 1", bus.flush_all, bus.flush_backend);
    end
    tick();
    tick();
    mispredict(0, 32'h600);
    tick();
    bus.mispredict_valid = 0;
    n_checks++;
    if (bus.flush_backend !== 0 || bus.busy !== 1 || bus.flush_count !== 16'd1) begin
      n_err++; $display("FAIL trap_ignore_mp: fb=%b busy=%b cnt=%0d required 0 1 1",
                        bus.flush_backend, bus.busy, bus.flush_count);
    end
    bus.backend_quiesced = 1;
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== 32'h80) begin
      n_err++; $display("FAIL trap_redirect: rv=%b pc=%h required 1 80", bus.redirect_valid, bus.redirect_pc);
    end
  endtask

  task automatic test_quiesce_wait();
    do_reset();
    bus.rob_head_idx = 4'd3;
    bus.backend_quiesced = 0;
    mispredict(9, 32'h700);
    tick();
    bus.mispredict_valid = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.redirect_valid !== 0 || bus.stall_fetch !== 1 || bus.busy !== 1 || bus.flush_backend !== 0) begin
        n_err++; $display("FAIL quiesce_hold[%0d]: rv=%b sf=%b busy=%b fb=%b required 0 1 1 0",
                          i, bus.redirect_valid, bus.stall_fetch, bus.busy, bus.flush_backend);
      end
    end
    bus.backend_quiesced = 1;
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== 32'h700) begin
      n_err++; $display("FAIL quiesce_release: rv=%b pc=%h required 1 700", bus.redirect_valid, bus.redirect_pc);
    end
  endtask

  task automatic test_stalls();
    do_reset();
    bus.hazard_stall = 1;
    #1;
    n_checks++;
    if ({bus.stall_fetch, bus.stall_decode, bus.stall_dispatch} !== 3'b111 || bus.busy !== 0) begin
      n_err++; $display("FAIL stall_hazard_idle: got %b%b%b busy=%b required 111 0",
                        bus.stall_fetch, bus.stall_decode, bus.stall_dispatch, bus.busy);
    end
    bus.hazard_stall = 0;
    mispredict(6, 32'h900);
    tick();
    bus.mispredict_valid = 0;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.stall_fetch !== 0 || bus.stall_dispatch !== 1 || bus.stall_decode !== 1) begin
      n_err++; $display("FAIL stall_redirect: rv=%b sf=%b sdp=%b sdc=%b required 1 0 1 1",
                        bus.redirect_valid, bus.stall_fetch, bus.stall_dispatch, bus.stall_decode);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rob_head_idx = 4'd3;
    bus.backend_quiesced = 0;
    mispredict(8, 32'hA00);
    tick();
    bus.mispredict_valid = 0;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    n_checks++;
    if (bus.busy !== 0 || bus.flush_count !== 16'd0 || bus.flush_rob_idx !== 4'd0 ||
        bus.redirect_pc !== 32'd0 || {bus.stall_fetch, bus.stall_decode, bus.stall_dispatch} !== 3'b111) begin
      n_err++; $display("FAIL reset_mid: busy=%b cnt=%0d idx=%0d pc=%h stalls=%b%b%b required 0 0 0 0 111",
                        bus.busy, bus.flush_count, bus.flush_rob_idx, bus.redirect_pc,
                        bus.stall_fetch, bus.stall_decode, bus.stall_dispatch);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    bus.backend_quiesced = 1;
    @(posedge clk);
    #1;
    mispredict(4, 32'hB00);
    tick();
    bus.mispredict_valid = 0;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.redirect_valid !== 1 || bus.redirect_pc !== 32'hB00 || bus.flush_count !== 16'd1) begin
      n_err++; $display("FAIL reset_mid_recover: rv=%b pc=%h cnt=%0d required 1 b00 1",
                        bus.redirect_valid, bus.redirect_pc, bus.flush_count);
    end
  endtask

  task automatic test_random();
    bit e_ff, e_fa, e_rv, e_busy, e_sf, e_sd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.hazard_stall       = ($urandom_range(0, 9) < 3);
      bus.rob_head_idx       = 4'($urandom_range(0, ROB - 1));
      bus.mispredict_valid   = ($urandom_range(0, 9) < 3);
      bus.mispredict_rob_idx = 4'($urandom_range(0, ROB - 1));
      bus.mispredict_target  = $urandom;
      bus.trap_valid         = ($urandom_range(0, 19) == 0);
      bus.trap_vector        = $urandom;
      bus.backend_quiesced   = ($urandom_range(0, 9) < 6);
      tick();
      bus.hazard_stall = ($urandom_range(0, 9) < 3);
      #1;
      e_ff   = (m_phase == 1);
      e_fa   = (m_phase == 1) && m_trap;
      e_rv   = (m_phase == 3);
      e_busy = (m_phase != 0);
      e_sf   = bus.hazard_stall || m_phase == 1 || m_phase == 2;
      e_sd   = bus.hazard_stall || e_busy;
      n_checks++;
      if (bus.flush_frontend !== e_ff || bus.flush_backend !== e_ff || bus.flush_all !== e_fa ||
          bus.redirect_valid !== e_rv || bus.busy !== e_busy) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: ff=%b fb=%b fa=%b rv=%b busy=%b required %b %b %b %b %b",
                          c, bus.flush_frontend, bus.flush_backend, bus.flush_all, bus.redirect_valid,
                          bus.busy, e_ff, e_ff, e_fa, e_rv, e_busy);
      end
      n_checks++;
      if (bus.stall_fetch !== e_sf || bus.stall_decode !== e_sd || bus.stall_dispatch !== e_sd) begin
        n_err++; $display("FAIL rand_stall[%0d]: sf=%b sdc=%b sdp=%b required %b %b %b",
                          c, bus.stall_fetch, bus.stall_decode, bus.stall_dispatch, e_sf, e_sd, e_sd);
      end
      n_checks++;
      if (bus.flush_count !== 16'(m_count)) begin
        n_err++; $display("FAIL rand_count[%0d]: got %0d required %0d", c, bus.flush_count, m_count);
      end
      if (m_phase == 1 && !m_trap) begin
        n_checks++;
        if (bus.flush_rob_idx !== 4'(m_idx)) begin
          n_err++; $display("FAIL rand_idx[%0d]: got %0d required %0d", c, bus.flush_rob_idx, m_idx);
        end
      end
      if (m_phase == 3) begin
        n_checks++;
        if (bus.redirect_pc !== m_pc) begin
          n_err++; $display("FAIL rand_pc[%0d]: got %h required %h", c, bus.redirect_pc, m_pc);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_mispredict();
    test_override();
    test_trap_priority();
    test_quiesce_wait();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
